jpeg_rle: RTL and testbench
===========================

// Module: jpeg_rle
// PURPOSE
//  Downstream of the DCT/quantizer stage. After a block is quantized, reads the 8x8 block from the output block RAM.
//  Words are 32-bit; 64 signed 16-bit coefficients are stored in natural row-major order.
//  Walks the block in zigzag order, DC-DPCM encodes the DC term and run-length encodes the AC terms.
//  Emits (run,size,amplitude) symbols on a valid/ready stream for the Huffman packer.
// PARAMETERS
//  COEF_W  16  coefficient width in RAM (two's complement)
//  AMP_W   12  amplitude/DC-difference width (size categories 0..12)
//  ADDR_W  5   RAM word address width (32 words per block)
// PORTS
//  clk_i        in   1       clock
//  rst_ni       in   1       asynchronous reset, active low
//  start_i      in   1       1-cycle pulse: encode the block now in RAM
//  dc_clr_i     in   1       clear DC predictor (start of scan)
//  busy_o       out  1       block in progress
//  done_o       out  1       1-cycle pulse after last symbol accepted
//  rd_en_o      out  1       RAM read enable
//  rd_addr_o    out  ADDR_W  RAM word address
//  rd_data_i    in   32      RAM data, valid 1 cycle after rd_en_o; [31:16]=coef 2k, [15:0]=coef 2k+1
//  sym_valid_o  out  1       symbol valid
//  sym_ready_i  in   1       consumer accepts symbol when valid&ready
//  sym_run_o    out  4       zero run preceding coefficient (0 for DC)
//  sym_size_o   out  4       size category = bit length of |value|
//  sym_amp_o    out  AMP_W   JPEG amplitude bits, low size bits only, upper bits 0
//  sym_dc_o     out  1       symbol is the DC difference
//  sym_last_o   out  1       final symbol of block
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; DC predictor 0; run counter 0; zigzag index 0.
//  Async reset mid-block aborts immediately; no done_o; predictor returns to 0.
//  FSM: IDLE -> FETCH -> EVAL -> {EMIT | ZRL | FETCH} ... -> EOB -> DONE -> IDLE.
//  IDLE: dc_clr_i clears the predictor. start_i moves to FETCH with n=0 and busy_o=1 the next cycle.
//    start_i is ignored while busy. dc_clr_i is ignored outside IDLE.
//  FETCH: rd_en_o=1, rd_addr_o=zz[n][5:1] (zz = 64-entry zigzag ROM -> natural index). Next state is EVAL.
//  EVAL: selects half v = zz[n][0] ? rd_data_i[15:0] : rd_data_i[31:16].
//    n=0: d = v - pred (AMP_W signed, no saturation); pred <= v; EMIT DC symbol with run=0.
//    n>0, v==0: run++. If n<63, n++ and go to FETCH. If n==63, go to EOB.
//    n>0, v!=0: while run>=16 go to ZRL; otherwise EMIT.
//  ZRL: symbol run=15, size=0, amp=0, dc=0, last=0. On accept, run -= 16 and return to EVAL path.
//    Data is held in an internal register, so the RAM is not re-read.
//  EMIT: symbol run=run, size, amp.
//    Amp is v for positive v and (v-1) truncated to size bits for negative v; 0 has size 0.
//    last=1 only when n==63. On accept, run=0. Then: n==63 -> DONE; else n++ -> FETCH.
//  EOB: symbol (0,0,0), last=1, dc=0. Emitted only if trailing zeros exist. On accept -> DONE.
//  DONE: done_o=1 for one cycle, busy_o=0 the next cycle, then IDLE.
//  Stream rule: once sym_valid_o=1, all sym_* fields stay stable until accepted. No combinational path from sym_ready_i to sym_valid_o.
//  Cost is 2 cycles per coefficient plus 1 per accepted symbol at full ready. Worst case is 192 cycles with no backpressure.
//  An all-zero AC run never produces ZRLs; only EOB is emitted.
// TESTING
//  1 All-zero block, pred=0 -> DC(run0,size0,amp0), then EOB(last=1), then done_o; exactly 2 symbols.
//  2 Block A DC=5 -> DC size3 amp101. Then block B DC=3, no dc_clr -> DC diff -2: size2 amp01.
//    dc_clr_i before B -> size2 amp11.
//  3 Only zigzag idx 20 nonzero (natural 40, word 20 [31:16]) = -1.
//    Expected: DC size0, then ZRL(15,0), then (run3,size1,amp0), then EOB.
//  4 Only natural idx 63 = 300 -> DC, (run15,0)x3, (run14,size9,amp 100101100, last=1); no EOB.
//  5 sym_ready_i low for 10 cycles mid-block -> valid held, fields stable; symbol sequence identical to the ready=1 run.
//  6 rst_ni low during EVAL of n=30 -> all outputs 0 asynchronously; a fresh start_i gives correct symbols with pred=0.

Source files
------------

// File: rtl/jpeg_rle.sv
// jpeg_rle: walks a quantized 8x8 block in zigzag order, DC-DPCM codes the DC term and
// run-length codes the AC terms into (run,size,amplitude) symbols on a valid/ready stream.
module jpeg_rle #(
    parameter int COEF_W = 16,
    parameter int AMP_W  = 12,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              dc_clr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    output logic              sym_valid_o,
    input  logic              sym_ready_i,
    output logic [3:0]        sym_run_o,
    output logic [3:0]        sym_size_o,
    output logic [AMP_W-1:0]  sym_amp_o,
    output logic              sym_dc_o,
    output logic              sym_last_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] EVAL  = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] ZRL   = 3'd4;
    localparam logic [2:0] EOB   = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    logic [2:0]        state;
    logic [5:0]        n;
    logic [5:0]        run;
    logic [COEF_W-1:0] pred;
    logic [AMP_W-1:0]  val;
    logic [5:0]        nat;
    logic [COEF_W-1:0] v;
    logic              accept;
    logic [AMP_W-1:0]  mag;
    logic [AMP_W-1:0]  raw;
    logic [3:0]        sz;
    assign nat         = ZZ[n];
    assign v           = nat[0] ? COEF_W'(rd_data_i[15:0]) : COEF_W'(rd_data_i[31:16]);
    assign accept      = sym_valid_o & sym_ready_i;
    assign mag         = val[AMP_W-1] ? -val : val;
    // negative amplitudes are the one's complement of |v|, i.e. v-1 in two's complement
    assign raw         = val[AMP_W-1] ? val - 1'b1 : val;
    assign busy_o      = state != IDLE;
    assign done_o      = state == DONE;
    assign rd_en_o     = state == FETCH;
    assign rd_addr_o   = state == FETCH ? ADDR_W'(nat[5:1]) : '0;
    assign sym_valid_o = (state == EMIT) || (state == ZRL) || (state == EOB);
    assign sym_run_o   = state == EMIT ? run[3:0] : state == ZRL ? 4'd15 : 4'd0;
    assign sym_size_o  = state == EMIT ? sz : 4'd0;
    assign sym_amp_o   = state == EMIT ? raw & ~({AMP_W{1'b1}} << sz) : '0;
    assign sym_dc_o    = (state == EMIT) && (n == 6'd0);
    assign sym_last_o  = ((state == EMIT) && (n == 6'd63)) || (state == EOB);
    always_comb begin
        sz = 4'd0;
        for (int i = 0; i < AMP_W; i++)
            if (mag[i]) sz = 4'(i + 1);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            n     <= '0;
            run   <= '0;
            pred  <= '0;
            val   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dc_clr_i) pred <= '0;
                    if (start_i) begin
                        state <= FETCH;
                        n     <= '0;
                        run   <= '0;
                    end
                end
                FETCH: state <= EVAL;
                EVAL: begin
                    if (n == 6'd0) begin
                        val   <= AMP_W'(v - pred);
                        pred  <= v;
                        state <= EMIT;
                    end else if (v == '0) begin
                        run   <= run + 6'd1;
                        n     <= n == 6'd63 ? n : n + 6'd1;
                        state <= n == 6'd63 ? EOB : FETCH;
                    end else begin
                        val   <= AMP_W'(v);
                        state <= run >= 6'd16 ? ZRL : EMIT;
                    end
                end
                // the coefficient stays in val, so no RAM re-read after a ZRL
                ZRL: if (accept) begin
                    run   <= run - 6'd16;
                    state <= run >= 6'd32 ? ZRL : EMIT;
                end
                EMIT: if (accept) begin
                    run   <= '0;
                    n     <= n == 6'd63 ? n : n + 6'd1;
                    state <= n == 6'd63 ? DONE : FETCH;
                end
                EOB: if (accept) begin
                    run   <= '0;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jpeg_rle.sv
// tb_jpeg_rle: randomized and directed checks of jpeg_rle against a queue-based symbol model.
module tb_jpeg_rle;
    logic        clk = 0;
    logic        rst_ni = 0;
    logic        start_i = 0;
    logic        dc_clr_i = 0;
    logic        sym_ready_i = 1;
    logic [31:0] rd_data_i = '0;
    logic        busy_o, done_o, rd_en_o, sym_valid_o, sym_dc_o, sym_last_o;
    logic [4:0]  rd_addr_o;
    logic [3:0]  sym_run_o, sym_size_o;
    logic [11:0] sym_amp_o;

    jpeg_rle dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .dc_clr_i(dc_clr_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .sym_valid_o(sym_valid_o), .sym_ready_i(sym_ready_i),
        .sym_run_o(sym_run_o), .sym_size_o(sym_size_o), .sym_amp_o(sym_amp_o),
        .sym_dc_o(sym_dc_o), .sym_last_o(sym_last_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

    int total = 0;
    int bad = 0;
    int zz [64];
    int coef [64];
    int pred_m = 0;
    int stall_cnt;
    logic [21:0] exp_q [$];
    logic [21:0] got_q [$];
    wire  [21:0] cur = {sym_run_o, sym_size_o, sym_amp_o, sym_dc_o, sym_last_o};

    function automatic logic [21:0] sym(int run, int size, int amp, bit dc, bit last);
        return {4'(run), 4'(size), 12'(amp), dc, last};
    endfunction

    function automatic logic [21:0] code(int run, int val, bit dc, bit last);
        int a = val < 0 ? -val : val;
        int size = 0;
        while ((a >> size) != 0) size++;
        return sym(run, size, val >= 0 ? val : val + (1 << size) - 1, dc, last);
    endfunction

    task automatic build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = s > 7 ? s - 7 : 0;
            int hi = s < 7 ? s : 7;
            if (s % 2 == 0)
                for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + s - r; k++; end
            else
                for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + s - r; k++; end
        end
    endtask

    task automatic load();
        for (int w = 0; w < 32; w++) mem[w] = {16'(coef[2 * w]), 16'(coef[2 * w + 1])};
    endtask

    task automatic gen(int dens);
        for (int i = 0; i < 64; i++)
            coef[i] = ($urandom % 100 < dens) ? int'($urandom_range(0, 4094)) - 2047 : 0;
        coef[0] = int'($urandom_range(0, 2046)) - 1023;
        load();
    endtask

    task automatic build_exp();
        int d = ((coef[0] - pred_m + 2048) % 4096 + 4096) % 4096 - 2048;
        int run = 0;
        exp_q.delete();
        exp_q.push_back(code(0, d, 1, 0));
        pred_m = coef[0];
        for (int k = 1; k < 64; k++) begin
            int v = coef[zz[k]];
            if (v == 0) run++;
            else begin
                while (run >= 16) begin exp_q.push_back(sym(15, 0, 0, 0, 0)); run -= 16; end
                exp_q.push_back(code(run, v, 0, k == 63));
                run = 0;
            end
        end
        if (coef[zz[63]] == 0) exp_q.push_back(sym(0, 0, 0, 0, 1));
    endtask

    // mode 0: ready always; mode 1: random ready and spurious start/dc_clr; mode 2: 10-cycle stall
    task automatic encode(bit clr, int mode);
        int cycles = 0;
        bit done = 0;
        bit pend = 0;
        logic [21:0] held = '0;
        if (clr) pred_m = 0;
        build_exp();
        got_q.delete();
        stall_cnt = 0;
        @(negedge clk);
        if (clr) begin dc_clr_i = 1; @(negedge clk); dc_clr_i = 0; end
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (done_o) begin
                done = 1; sym_ready_i = 1; start_i = 0; dc_clr_i = 0;
                break;
            end
            if (pend) begin
                total++;
                if (!sym_valid_o || cur !== held) begin
                    bad++;
                    $display("FAIL hold: valid=%b fields=%h want valid=1 fields=%h", sym_valid_o, cur, held);
                end
            end
            if (mode == 1) begin
                sym_ready_i = ($urandom % 3) != 0;
                start_i = ($urandom % 5) == 0;
                dc_clr_i = ($urandom % 5) == 0;
            end else if (mode == 2 && got_q.size() == 3 && stall_cnt < 10 && sym_valid_o) begin
                sym_ready_i = 0;
                stall_cnt++;
            end else sym_ready_i = 1;
            if (sym_valid_o && sym_ready_i) got_q.push_back(cur);
            pend = sym_valid_o && !sym_ready_i;
            held = cur;
        end
        total++;
        if (!done) begin bad++; $display("FAIL done: no done_o after %0d cycles", cycles); end
        @(negedge clk);
        total++;
        if (busy_o !== 0 || done_o !== 0) begin
            bad++;
            $display("FAIL idle: busy=%b done=%b want 0 0", busy_o, done_o);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL count: got %0d symbols want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL sym[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 0;
        #12;
        total++;
        if ({busy_o, done_o, rd_en_o, rd_addr_o, sym_valid_o, cur} !== '0) begin
            bad++;
            $display("FAIL reset: outputs %h want 0", {busy_o, done_o, rd_en_o, rd_addr_o, sym_valid_o, cur});
        end
        @(negedge clk);
        rst_ni = 1;
        pred_m = 0;
    endtask

    task automatic test_zero();
        for (int i = 0; i < 64; i++) coef[i] = 0;
        load();
        encode(0, 0);
        total++;
        if (got_q.size() != 2 || got_q[0] !== sym(0, 0, 0, 1, 0) || got_q[1] !== sym(0, 0, 0, 0, 1)) begin
            bad++;
            $display("FAIL zero: got %0d symbols first %h want 2 symbols %h", got_q.size(), got_q[0], sym(0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_dc_dpcm();
        for (int i = 0; i < 64; i++) coef[i] = 0;
        coef[0] = 5; load();
        encode(1, 0);
        total++;
        if (got_q[0] !== sym(0, 3, 5, 1, 0)) begin bad++; $display("FAIL dc_a: got %h want %h", got_q[0], sym(0, 3, 5, 1, 0)); end
        coef[0] = 3; load();
        encode(0, 0);
        total++;
        if (got_q[0] !== sym(0, 2, 1, 1, 0)) begin bad++; $display("FAIL dc_b: got %h want %h", got_q[0], sym(0, 2, 1, 1, 0)); end
        encode(1, 0);
        total++;
        if (got_q[0] !== sym(0, 2, 3, 1, 0)) begin bad++; $display("FAIL dc_clr: got %h want %h", got_q[0], sym(0, 2, 3, 1, 0)); end
    endtask

    task automatic test_zrl();
        logic [21:0] want [4];
        want = '{sym(0, 0, 0, 1, 0), sym(15, 0, 0, 0, 0), sym(3, 1, 0, 0, 0), sym(0, 0, 0, 0, 1)};
        for (int i = 0; i < 64; i++) coef[i] = 0;
        coef[40] = -1; load();
        encode(1, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q[i] !== want[i]) begin bad++; $display("FAIL zrl[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_last();
        logic [21:0] want [5];
        want = '{sym(0, 0, 0, 1, 0), sym(15, 0, 0, 0, 0), sym(15, 0, 0, 0, 0), sym(15, 0, 0, 0, 0), sym(14, 9, 300, 0, 1)};
        for (int i = 0; i < 64; i++) coef[i] = 0;
        coef[63] = 300; load();
        encode(1, 0);
        total++;
        if (got_q.size() != 5) begin bad++; $display("FAIL last_cnt: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_q[i] !== want[i]) begin bad++; $display("FAIL last[%0d]: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_random();
        int dens [8] = '{0, 3, 10, 25, 50, 75, 100, 40};
        for (int i = 0; i < 8; i++) begin
            gen(dens[i]);
            encode($urandom % 2, 1);
        end
    endtask

    task automatic test_backpressure();
        gen(60);
        encode(0, 2);
        total++;
        if (stall_cnt != 10) begin bad++; $display("FAIL stall: got %0d stall cycles want 10", stall_cnt); end
    endtask

    task automatic test_abort();
        int fetches = 0;
        int cycles = 0;
        gen(50);
        sym_ready_i = 1;
        @(negedge clk);
        start_i = 1;
        @(negedge clk);
        start_i = 0;
        while (fetches < 31 && cycles < 1000) begin
            if (rd_en_o) fetches++;
            if (fetches < 31) begin @(negedge clk); cycles++; end
        end
        total++;
        if (fetches != 31) begin bad++; $display("FAIL abort_fetch: got %0d fetches want 31", fetches); end
        @(posedge clk);
        #2 rst_ni = 0;
        #1;
        total++;
        if ({busy_o, done_o, rd_en_o, rd_addr_o, sym_valid_o, cur} !== '0) begin
            bad++;
            $display("FAIL abort: outputs %h want 0", {busy_o, done_o, rd_en_o, rd_addr_o, sym_valid_o, cur});
        end
        @(negedge clk);
        rst_ni = 1;
        pred_m = 0;
        gen(30);
        encode(0, 0);
    endtask

    initial begin
        build_zz();
        test_reset();
        test_zero();
        test_dc_dpcm();
        test_zrl();
        test_last();
        test_random();
        test_backpressure();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
